// File: rtl/ula_pkg.sv
// Shared definitions for the 74181-style ALU family: function-select codes
// and the serial ALU's FSM state type.
package ula_pkg;

  localparam logic [3:0] ULA_S_ADD = 4'b1001;
  localparam logic [3:0] ULA_S_SUB = 4'b0110;
  localparam logic [3:0] ULA_S_XOR = 4'b0110;  // same code, used with m=1
  localparam logic [3:0] ULA_S_AND = 4'b1011;
  localparam logic [3:0] ULA_S_OR  = 4'b1110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ula_serial_state_t;

endpackage

// File: rtl/ula_74181.sv
// Combinational 4-bit 74181 ALU slice, active-high data and carry.
// q/r are the per-bit propagate/generate terms of the datasheet's internal gates.
module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       a_eq_b,
  output logic       c_out,
  output logic       p,
  output logic       g
);

  logic [3:0] q;
  logic [3:0] r;
  logic [4:0] c;

  always_comb begin
    q = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    r = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    c = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = r[i] | (q[i] & c[i]);
    end
    // Logic mode behaves as if every internal carry were forced high.
    f      = m ? ~(q ^ r) : (q ^ r ^ c[3:0]);
    a_eq_b = &f;
    c_out  = c[4];
    p      = &q;
    g      = r[3] | (q[3] & r[2]) | (q[3] & q[2] & r[1]) | (q[3] & q[2] & q[1] & r[0]);
  end

endmodule

// File: rtl/ula_74181_serial.sv
// WIDTH-bit ALU that iterates one ula_74181 slice over the nibbles, LSB first.
// Optional z/n result flags are enabled with `define ULA_SERIAL_FLAGS_EN.
module ula_74181_serial
  import ula_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [3:0]        s,
  input  logic              m,
  input  logic              c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  f,
  output logic              a_eq_b,
  output logic              c_out,
  output logic              p,
  output logic              g,
`ifdef ULA_SERIAL_FLAGS_EN
  output logic              z,
  output logic              n,
`endif
  output ula_serial_state_t state_dbg
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("ula_74181_serial: WIDTH must be a multiple of 4 and >= 4");
  end

  ula_serial_state_t state, state_next;

  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_reg, b_reg, f_reg;
  logic [3:0]       s_reg;
  logic             m_reg;
  logic             carry_reg, p_acc, g_acc, eq_acc;
  logic             accept;

  logic [3:0] slice_a, slice_b, slice_f;
  logic       slice_eq, slice_c, slice_p, slice_g;

  // Handshake: a command transfers on a cycle with in_valid & in_ready, a result
  // on a cycle with out_valid & out_ready; neither side may retract early.
  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

  assign slice_a = a_reg[{idx, 2'b00} +: 4];
  assign slice_b = b_reg[{idx, 2'b00} +: 4];

  ula_74181 u_slice (
    .a      (slice_a),
    .b      (slice_b),
    .s      (s_reg),
    .m      (m_reg),
    .c_in   (carry_reg),
    .f      (slice_f),
    .a_eq_b (slice_eq),
    .c_out  (slice_c),
    .p      (slice_p),
    .g      (slice_g)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)        state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (out_ready)       state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      m_reg     <= 1'b0;
      f_reg     <= '0;
      carry_reg <= 1'b0;
      p_acc     <= 1'b0;
      g_acc     <= 1'b0;
      eq_acc    <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= a;
      b_reg     <= b;
      s_reg     <= s;
      m_reg     <= m;
      carry_reg <= c_in;
      p_acc     <= 1'b1;
      g_acc     <= 1'b0;
      eq_acc    <= 1'b1;
    end else if (state == RUN) begin
      f_reg[{idx, 2'b00} +: 4] <= slice_f;
      carry_reg <= slice_c;
      // Fold this nibble in as the more significant group.
      g_acc     <= slice_g | (slice_p & g_acc);
      p_acc     <= p_acc & slice_p;
      eq_acc    <= eq_acc & slice_eq;
      if (idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign f      = f_reg;
  assign c_out  = carry_reg;
  assign p      = p_acc;
  assign g      = g_acc;
  assign a_eq_b = eq_acc;

`ifdef ULA_SERIAL_FLAGS_EN
  logic z_acc, n_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      z_acc <= 1'b0;
      n_reg <= 1'b0;
    end else if (accept) begin
      z_acc <= 1'b1;
    end else if (state == RUN) begin
      z_acc <= z_acc & (slice_f == 4'h0);
      if (idx == LAST_IDX) begin
        n_reg <= slice_f[3];
      end
    end
  end

  assign z = z_acc;
  assign n = n_reg;
`endif

endmodule

// File: tb/tb_ula_74181_serial.sv
// Self-checking bench for ula_74181_serial (WIDTH=16) against a word-level
// model of the 74181 function table.
module tb_ula_74181_serial;
  import ula_pkg::*;

  localparam int W = 16;
  localparam int NS = W / 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, f;
  logic [3:0] s;
  logic m, c_in, a_eq_b, c_out, p, g;
`ifdef ULA_SERIAL_FLAGS_EN
  logic z, n;
`endif
  ula_serial_state_t state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  ula_74181_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .f(f),
    .a_eq_b(a_eq_b), .c_out(c_out), .p(p), .g(g),
`ifdef ULA_SERIAL_FLAGS_EN
    .z(z), .n(n),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Reference model: datasheet operand pairs (x plus y plus c_in) for m=0,
  // the logic table for m=1; carry chain independent of m.
  function automatic void ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                 input logic [3:0] rs, input logic rm, input logic rci,
                                 output logic [W-1:0] rf, output logic rc,
                                 output logic rp, output logic rg, output logic req);
    logic [W-1:0] x, y, ones;
    logic [W:0] sum, sum0;
    ones = '1;
    case (rs)
      4'h0: begin x = ra;       y = '0;       end
      4'h1: begin x = ra | rb;  y = '0;       end
      4'h2: begin x = ra | ~rb; y = '0;       end
      4'h3: begin x = ones;     y = '0;       end
      4'h4: begin x = ra;       y = ra & ~rb; end
      4'h5: begin x = ra | rb;  y = ra & ~rb; end
      4'h6: begin x = ra;       y = ~rb;      end
      4'h7: begin x = ra & ~rb; y = ones;     end
      4'h8: begin x = ra;       y = ra & rb;  end
      4'h9: begin x = ra;       y = rb;       end
      4'hA: begin x = ra | ~rb; y = ra & rb;  end
      4'hB: begin x = ra & rb;  y = ones;     end
      4'hC: begin x = ra;       y = ra;       end
      4'hD: begin x = ra | rb;  y = ra;       end
      4'hE: begin x = ra | ~rb; y = ra;       end
      default: begin x = ra;    y = ones;     end
    endcase
    sum0 = {1'b0, x} + {1'b0, y};
    sum  = sum0 + {{W{1'b0}}, rci};
    rc = sum[W];
    rg = sum0[W];
    rp = &(x | y);
    if (!rm) begin
      rf = sum[W-1:0];
    end else begin
      case (rs)
        4'h0: rf = ~ra;
        4'h1: rf = ~(ra | rb);
        4'h2: rf = ~ra & rb;
        4'h3: rf = '0;
        4'h4: rf = ~(ra & rb);
        4'h5: rf = ~rb;
        4'h6: rf = ra ^ rb;
        4'h7: rf = ra & ~rb;
        4'h8: rf = ~ra | rb;
        4'h9: rf = ~(ra ^ rb);
        4'hA: rf = rb;
        4'hB: rf = ra & rb;
        4'hC: rf = ones;
        4'hD: rf = ra | ~rb;
        4'hE: rf = ra | rb;
        default: rf = ra;
      endcase
    end
    req = &rf;
  endfunction

  // Driver: present a command, then scramble inputs while the DUT runs.
  // Returns edges from accept to out_valid (-1 on timeout), parked at a negedge.
  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [3:0] ts, input logic tm, input logic tci,
                          output int lat);
    int guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk); guard++;
    end
    a = ta; b = tb_v; s = ts; m = tm; c_in = tci; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom); c_in = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++; if (in_ready !== 1'b1)  begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (f !== '0)           begin n_err++; $display("FAIL reset_f: got %h want 0", f); end
    n_cmp++; if ({a_eq_b, c_out, p, g} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got eq/c/p/g=%b want 0000", {a_eq_b, c_out, p, g});
    end
    n_cmp++; if (state_dbg !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
`ifdef ULA_SERIAL_FLAGS_EN
    n_cmp++; if ({z, n} !== 2'b00) begin n_err++; $display("FAIL reset_zn: got %b want 00", {z, n}); end
`endif
  endtask

  task automatic test_directed();
    int lat;
    drive_op(16'h1234, 16'h0FFF, ULA_S_ADD, 1'b0, 1'b0, lat);
    n_cmp++; if (lat != NS) begin n_err++; $display("FAIL add_latency: got %0d want %0d", lat, NS); end
    n_cmp++; if ({f, c_out} !== {16'h2233, 1'b0}) begin
      n_err++; $display("FAIL add: got f=%h c=%b want f=2233 c=0", f, c_out);
    end
    release_op();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL add_release: got ready/valid=%b want 10", {in_ready, out_valid});
    end

    drive_op(16'h5555, 16'hAAAA, ULA_S_ADD, 1'b0, 1'b1, lat);
    n_cmp++; if ({f, c_out, p, g} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL add_carry: got f=%h c=%b p=%b g=%b want 0000 1 1 0", f, c_out, p, g);
    end
    release_op();

    drive_op(16'hF0F0, 16'hFF00, ULA_S_XOR, 1'b1, 1'b1, lat);
    n_cmp++; if (f !== 16'h0FF0) begin n_err++; $display("FAIL xor: got %h want 0ff0", f); end
    release_op();

    drive_op(16'h1234, 16'h1234, ULA_S_SUB, 1'b0, 1'b0, lat);
    n_cmp++; if ({f, a_eq_b} !== {16'hFFFF, 1'b1}) begin
      n_err++; $display("FAIL cmp_equal: got f=%h eq=%b want ffff 1", f, a_eq_b);
    end
    release_op();

    drive_op(16'h1234, 16'h1235, ULA_S_SUB, 1'b0, 1'b0, lat);
    n_cmp++; if ({f, a_eq_b} !== {16'hFFFE, 1'b0}) begin
      n_err++; $display("FAIL cmp_unequal: got f=%h eq=%b want fffe 0", f, a_eq_b);
    end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] ef;
    logic ec, ep, eg, eq;
    ref_op(16'hBEEF, 16'h1357, ULA_S_AND, 1'b1, 1'b0, ef, ec, ep, eg, eq);
    drive_op(16'hBEEF, 16'h1357, ULA_S_AND, 1'b1, 1'b0, lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
      n_cmp++; if ({out_valid, in_ready, f, c_out, p, g, a_eq_b} !== {1'b1, 1'b0, ef, ec, ep, eg, eq}) begin
        n_err++; $display("FAIL backpressure[%0d]: got v=%b r=%b f=%h cpge=%b want 1 0 %h %b",
                          k, out_valid, in_ready, f, {c_out, p, g, a_eq_b}, ef, {ec, ep, eg, eq});
      end
    end
    release_op();
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin
      n_err++; $display("FAIL backpressure_release: got ready/valid=%b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] ra, rb, ef, exp_f;
    logic [3:0] rs;
    logic rm, rci, ec, ep, eg, eq;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 4'($urandom); rm = 1'($urandom); rci = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      ref_op(ra, rb, rs, rm, rci, ef, ec, ep, eg, eq);
      exp_q.push_back(ef);
      drive_op(ra, rb, rs, rm, rci, lat);
      exp_f = exp_q.pop_front();
      n_cmp++; if (lat != NS || f !== exp_f || {c_out, p, g, a_eq_b} !== {ec, ep, eg, eq}) begin
        n_err++; $display("FAIL random[%0d] s=%h m=%b a=%h b=%h ci=%b: got lat=%0d f=%h cpge=%b want lat=%0d f=%h cpge=%b",
                          i, rs, rm, ra, rb, rci, lat, f, {c_out, p, g, a_eq_b}, NS, exp_f, {ec, ep, eg, eq});
      end
`ifdef ULA_SERIAL_FLAGS_EN
      n_cmp++; if ({z, n} !== {(exp_f == '0), exp_f[W-1]}) begin
        n_err++; $display("FAIL random_zn[%0d]: got %b want %b", i, {z, n}, {(exp_f == '0), exp_f[W-1]});
      end
`endif
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_op();
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    logic [W-1:0] ef;
    logic ec, ep, eg, eq;
    ref_op(16'h7FFF, 16'h0001, ULA_S_ADD, 1'b0, 1'b0, ef, ec, ep, eg, eq);
    a = 16'h7FFF; b = 16'h0001; s = ULA_S_ADD; m = 1'b0; c_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 40 && t.size() < 3; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        t.push_back(k);
        n_cmp++; if (f !== ef) begin n_err++; $display("FAIL b2b_f[%0d]: got %h want %h", t.size(), f, ef); end
        if (t.size() == 3) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (t.size() != 3) begin
      n_err++; $display("FAIL b2b_count: got %0d results want 3", t.size());
    end else if ((t[1] - t[0]) != NS + 2 || (t[2] - t[1]) != NS + 2) begin
      n_err++; $display("FAIL b2b_spacing: got %0d,%0d want %0d", t[1] - t[0], t[2] - t[1], NS + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    a = 16'hFFFF; b = 16'h0000; s = ULA_S_ADD; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if ({out_valid, in_ready, f} !== {1'b0, 1'b1, 16'h0000}) begin
      n_err++; $display("FAIL mid_reset: got v=%b r=%b f=%h want 0 1 0000", out_valid, in_ready, f);
    end
    @(negedge clk);
    drive_op(16'h0001, 16'h0001, ULA_S_ADD, 1'b0, 1'b0, lat);
    n_cmp++; if (lat != NS || f !== 16'h0002) begin
      n_err++; $display("FAIL after_reset_add: got lat=%0d f=%h want %0d 0002", lat, f, NS);
    end
    release_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
